// File: rtl/keypad_move_scanner.sv
// Keypad row scanner, frame debouncer and direction-pulse generator for the maze cursor.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of the direction pulse while a key stays held.
module keypad_move_scanner #(
  parameter int SCAN_DIV      = 16384,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_FRAMES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] column,
  output logic [2:0] sel,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int              SLOT_W     = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_TARGET = 4'(DEBOUNCE);
  localparam logic [3:0]      CODE_NONE  = 4'hF;

  // Row/pattern/code table for the four direction keys, indexed {k2,k4,k6,k8}.
  localparam logic [2:0] KEY_SEL [4] = '{3'd0, 3'd1, 3'd1, 3'd2};
  localparam logic [2:0] KEY_PAT [4] = '{3'b101, 3'b011, 3'b110, 3'b101};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB,
    ST_HELD,
    ST_REL
  } state_t;

  // An illegal parameter set elaborates this marker so it shows up in reports.
  if (SCAN_DIV < 2 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 1) begin : g_bad_params
    logic bad_params_flag;
    assign bad_params_flag = 1'b1;
  end

  logic [SLOT_W-1:0] slot_cnt_reg;
  logic [2:0]        sel_reg;
  logic [3:0]        frame_vec_reg;
  logic [3:0]        key_hit;
  logic              slot_last;
  logic              frame_end;
  logic [3:0]        frame_code;

  state_t     state_reg;
  logic [3:0] cand_reg;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_inc;
  logic [3:0] dir_reg;
  logic [3:0] key_code_reg;
  logic       key_valid_reg;

  assign slot_last = (slot_cnt_reg == SLOT_LAST);
  assign frame_end = slot_last && (sel_reg == 3'd5);
  assign cnt_inc   = (cnt_reg == 4'hF) ? 4'hF : cnt_reg + 4'd1;

  function automatic logic [3:0] dir_of(input logic [3:0] code);
    case (code)
      4'd2:    dir_of = 4'b1000;
      4'd8:    dir_of = 4'b0100;
      4'd4:    dir_of = 4'b0010;
      4'd6:    dir_of = 4'b0001;
      default: dir_of = 4'b0000;
    endcase
  endfunction

  // Slot counter and row select: sel moves on the edge that ends each slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_cnt_reg <= '0;
      sel_reg      <= 3'd0;
    end else if (slot_last) begin
      slot_cnt_reg <= '0;
      sel_reg      <= (sel_reg == 3'd5) ? 3'd0 : sel_reg + 3'd1;
    end else begin
      slot_cnt_reg <= slot_cnt_reg + SLOT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      assign key_hit[gi] = (sel_reg == KEY_SEL[gi]) && (column == KEY_PAT[gi]);
    end
  endgenerate

  // Samples accumulate over slots 0..2; the frame is judged and cleared at frame end.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_vec_reg <= 4'b0000;
    end else if (frame_end) begin
      frame_vec_reg <= 4'b0000;
    end else if (slot_last) begin
      frame_vec_reg <= frame_vec_reg | key_hit;
    end
  end

  always_comb begin
    frame_code = CODE_NONE;
    case (frame_vec_reg)
      4'b0001: frame_code = 4'd2;
      4'b0010: frame_code = 4'd4;
      4'b0100: frame_code = 4'd6;
      4'b1000: frame_code = 4'd8;
      default: frame_code = CODE_NONE;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int              REP_W    = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
  logic [REP_W-1:0] rep_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cand_reg      <= CODE_NONE;
      cnt_reg       <= 4'd0;
      dir_reg       <= 4'b0000;
      key_code_reg  <= CODE_NONE;
      key_valid_reg <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg   <= '0;
`endif
    end else begin
      dir_reg <= 4'b0000;
      if (frame_end) begin
        case (state_reg)
          ST_IDLE: begin
            if (frame_code != CODE_NONE) begin
              cand_reg <= frame_code;
              cnt_reg  <= 4'd1;
              if (DEBOUNCE == 1) begin
                state_reg     <= ST_HELD;
                dir_reg       <= dir_of(frame_code);
                key_code_reg  <= frame_code;
                key_valid_reg <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_reg   <= '0;
`endif
              end else begin
                state_reg <= ST_DEB;
              end
            end
          end
          ST_DEB: begin
            if (frame_code == CODE_NONE) begin
              state_reg <= ST_IDLE;
            end else if (frame_code != cand_reg) begin
              cand_reg <= frame_code;
              cnt_reg  <= 4'd1;
            end else begin
              cnt_reg <= cnt_inc;
              if (cnt_inc >= DEB_TARGET) begin
                state_reg     <= ST_HELD;
                dir_reg       <= dir_of(cand_reg);
                key_code_reg  <= cand_reg;
                key_valid_reg <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_reg   <= '0;
`endif
              end
            end
          end
          ST_HELD: begin
            if (frame_code == cand_reg) begin
`ifdef KEYPAD_REPEAT_EN
              if (rep_cnt_reg == REP_LAST) begin
                rep_cnt_reg <= '0;
                dir_reg     <= dir_of(cand_reg);
              end else begin
                rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
              end
`endif
            end else begin
              cnt_reg <= 4'd1;
              if (DEBOUNCE == 1) begin
                state_reg     <= ST_IDLE;
                key_code_reg  <= CODE_NONE;
                key_valid_reg <= 1'b0;
              end else begin
                state_reg <= ST_REL;
              end
            end
          end
          ST_REL: begin
            // A returning candidate resumes the hold silently: no second press.
            if (frame_code == cand_reg) begin
              state_reg <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_reg <= '0;
`endif
            end else begin
              cnt_reg <= cnt_inc;
              if (cnt_inc >= DEB_TARGET) begin
                state_reg     <= ST_IDLE;
                key_code_reg  <= CODE_NONE;
                key_valid_reg <= 1'b0;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign sel                     = sel_reg;
  assign {up, down, left, right} = dir_reg;
  assign key_code                = key_code_reg;
  assign key_valid               = key_valid_reg;

endmodule

// File: tb/tb_keypad_move_scanner.sv
// Self-checking bench for keypad_move_scanner: directed scenarios plus random key traffic vs a frame-history model.
module tb_keypad_move_scanner;

  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE      = 3;
  localparam int REPEAT_FRAMES = 2;
  localparam int FRAME         = 6 * SCAN_DIV;
  localparam int MULTI         = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] column = 3'b111;
  logic [2:0] sel;
  logic       up, down, left, right;
  logic [3:0] key_code;
  logic       key_valid;

  always #5 clk = ~clk;

  keypad_move_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE),
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .column(column),
    .sel(sel),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .key_code(key_code),
    .key_valid(key_valid)
  );

  int total = 0;
  int bad   = 0;

  int   n;
  int   cur_key;
  bit   noisy;
  int   fkeys[$];
  int   hist[$];
  int   held_key;
  int   idle_start;
  int   rep_base;
  int   cnt_pulse[4];
  logic [3:0] exp_pulse;
  logic [3:0] exp_code;
  logic       exp_valid;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sample_key(input int s, input logic [2:0] c);
    if (s == 0 && c == 3'b101) return 2;
    if (s == 1 && c == 3'b011) return 4;
    if (s == 1 && c == 3'b110) return 6;
    if (s == 2 && c == 3'b101) return 8;
    return 0;
  endfunction

  function automatic logic [2:0] drive_pat(input int s, input int key);
    if (key == 2 && s == 0) return 3'b101;
    if (key == 4 && s == 1) return 3'b011;
    if (key == 6 && s == 1) return 3'b110;
    if (key == 8 && s == 2) return 3'b101;
    if (key == MULTI && s == 1) return 3'b010;
    return 3'b111;
  endfunction

  function automatic logic [3:0] pulse_of(input int k);
    case (k)
      2:       return 4'b1000;
      8:       return 4'b0100;
      4:       return 4'b0010;
      6:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Frame-level model over the history of judged frames since reset.
  task automatic frame_update(input int v);
    int f;
    int run;
    int gap;
    hist.push_back(v);
    f = hist.size() - 1;
    if (held_key == 0) begin
      if (v != 0) begin
        run = 0;
        for (int i = f; i > idle_start && hist[i] == v; i--) run++;
        if (run == DEBOUNCE) begin
          held_key  = v;
          rep_base  = f;
          exp_pulse = pulse_of(v);
          exp_code  = 4'(v);
          exp_valid = 1'b1;
        end
      end
    end else if (v == held_key) begin
      if (hist[f-1] != held_key) begin
        rep_base = f;
      end
`ifdef KEYPAD_REPEAT_EN
      else if ((f - rep_base) % REPEAT_FRAMES == 0) begin
        exp_pulse = pulse_of(v);
      end
`endif
    end else begin
      gap = 0;
      for (int i = f; i >= 0 && hist[i] != held_key; i--) gap++;
      if (gap >= DEBOUNCE) begin
        held_key   = 0;
        idle_start = f;
        exp_code   = 4'hF;
        exp_valid  = 1'b0;
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset  = 1'b0;
    column = 3'b111;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_sel", 8'(sel), 8'd0);
      check("rst_pulse", 8'({up, down, left, right}), 8'd0);
      check("rst_code", 8'(key_code), 8'h0F);
      check("rst_valid", 8'(key_valid), 8'd0);
    end
    reset      = 1'b1;
    n          = 0;
    hist.delete();
    fkeys.delete();
    held_key   = 0;
    idle_start = -1;
    rep_base   = 0;
    exp_pulse  = 4'b0000;
    exp_code   = 4'hF;
    exp_valid  = 1'b0;
  endtask

  task automatic tick();
    int s;
    int k;
    logic [3:0] obs_p;
    s     = (n / SCAN_DIV) % 6;
    obs_p = {up, down, left, right};
    check("sel", 8'(sel), 8'(s));
    check("pulse", 8'(obs_p), 8'(exp_pulse));
    check("code", 8'(key_code), 8'(exp_code));
    check("valid", 8'(key_valid), 8'(exp_valid));
    for (int b = 0; b < 4; b++) if (obs_p[b]) cnt_pulse[b]++;
    if (n % SCAN_DIV == SCAN_DIV - 1) begin
      if (s <= 2 && !(noisy && cur_key == 0)) column = drive_pat(s, cur_key);
      else column = 3'($urandom);
    end else begin
      column = 3'($urandom);
    end
    @(posedge clk);
    exp_pulse = 4'b0000;
    if (n % SCAN_DIV == SCAN_DIV - 1) begin
      k = sample_key(s, column);
      if (k != 0) fkeys.push_back(k);
    end
    if (n % FRAME == FRAME - 1) begin
      if (fkeys.size() == 1) frame_update(fkeys[0]);
      else frame_update(0);
      fkeys.delete();
    end
    n++;
    @(negedge clk);
  endtask

  task automatic run_frames(input int key, input int nf);
    cur_key = key;
    repeat (nf * FRAME) tick();
  endtask

  task automatic clear_counts();
    for (int b = 0; b < 4; b++) cnt_pulse[b] = 0;
  endtask

  initial begin
    int keys[6];
    int exp_up;
    int exp_down;
    keys    = '{0, 2, 4, 6, 8, MULTI};
    cur_key = 0;
    noisy   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    exp_up   = 2;
    exp_down = 4;
`else
    exp_up   = 1;
    exp_down = 1;
`endif

    apply_reset(5);
    clear_counts();
    run_frames(0, 2);
    check("idle_pulses", 8'(cnt_pulse[0] + cnt_pulse[1] + cnt_pulse[2] + cnt_pulse[3]), 8'd0);

    clear_counts();
    run_frames(2, 5);
    run_frames(0, 4);
    check("press_up", 8'(cnt_pulse[3]), 8'(exp_up));
    check("press_other", 8'(cnt_pulse[0] + cnt_pulse[1] + cnt_pulse[2]), 8'd0);

    clear_counts();
    run_frames(6, 2);
    run_frames(0, 1);
    run_frames(6, 3);
    run_frames(0, 4);
    check("bounce_right", 8'(cnt_pulse[0]), 8'd1);
    check("bounce_other", 8'(cnt_pulse[1] + cnt_pulse[2] + cnt_pulse[3]), 8'd0);

    clear_counts();
    run_frames(MULTI, 6);
    run_frames(0, 1);
    check("multi_pulses", 8'(cnt_pulse[0] + cnt_pulse[1] + cnt_pulse[2] + cnt_pulse[3]), 8'd0);

    clear_counts();
    run_frames(8, 10);
    run_frames(0, 4);
    check("held_down", 8'(cnt_pulse[2]), 8'(exp_down));
    check("held_other", 8'(cnt_pulse[0] + cnt_pulse[1] + cnt_pulse[3]), 8'd0);

    run_frames(4, 4);
    cur_key = 4;
    repeat (7) tick();
    check("pre_reset_valid", 8'(key_valid), 8'd1);
    apply_reset(2);
    clear_counts();
    run_frames(4, 4);
    run_frames(0, 4);
    check("after_reset_left", 8'(cnt_pulse[1]), 8'd1);

    noisy = 1'b1;
    repeat (30) begin
      run_frames(keys[$urandom_range(0, 5)], int'($urandom_range(1, 5)));
    end
    noisy = 1'b0;
    run_frames(0, 4);
    check("final_valid", 8'(key_valid), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_move_scanner.md
# keypad_move_scanner

Scans the 3-column keypad, debounces it and turns the four direction keys (2/4/6/8) into single-cycle move pulses plus a 4-bit key code for the maze datapath. The block replaces the separate row counter, decoder, press-validation and key-buffer chain that sits upstream of the cursor-movement logic. It drives the keypad row-select lines and feeds `up/down/left/right` straight into the cursor shift registers.

## Interface

Parameters:
- `SCAN_DIV`, 16384: clk cycles per row-select slot; legal range ≥2.
- `DEBOUNCE`, 3: consecutive identical frames required to accept a press or release; legal range 1–15.
- `REPEAT_FRAMES`, 20: frames between auto-repeat pulses; used only with `KEYPAD_REPEAT_EN`.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-low reset (sampled on rising `clk`).
- `column`  in  3: keypad column sense, active-low (0 = key closed in the selected row).
- `sel`  out  3: row select, counts 0..5.
- `up`  out  1: one-cycle pulse for key 2.
- `down`  out  1: one-cycle pulse for key 8.
- `left`  out  1: one-cycle pulse for key 4.
- `right`  out  1: one-cycle pulse for key 6.
- `key_code`  out  4: code of the accepted key (4'd2/4/6/8). 4'hF when no key is accepted.
- `key_valid`  out  1: high while `key_code` holds an accepted key.

## Operation

- **Slot counter.**
  - The slot counter runs 0..SCAN_DIV-1.
  - At terminal count, `sel` advances and wraps 5→0.
  - One frame = 6·SCAN_DIV cycles.
- **Sampling.** `column` is sampled on the last cycle of each slot.
  - sel=0, column=3'b101 → key 2.
  - sel=1, column=3'b011 → key 4.
  - sel=1, column=3'b110 → key 6.
  - sel=2, column=3'b101 → key 8.
  - All other patterns, and sel 3–5, contribute nothing.
- **Frame vector.**
  - The four samples are collected into a 4-bit frame vector `{k8,k6,k4,k2}`.
  - The vector is latched at the end of slot 5 (frame end).
  - The frame value is the key whose bit is set when exactly one bit is set.
  - Zero bits or ≥2 bits set (simultaneous keys) → frame value NONE.
- **Debounce FSM.** Evaluated once per frame end.
  - IDLE: frame value ≠ NONE → load candidate, cnt=1, go to DEB. If DEBOUNCE=1, go directly to HELD and fire.
  - DEB: same candidate → cnt+1; on cnt==DEBOUNCE → HELD and fire. Different key → reload candidate, cnt=1. NONE → IDLE.
  - HELD: same key → stay. Anything else (NONE or other key) → REL, cnt=1.
  - REL: DEBOUNCE consecutive non-candidate frames → IDLE. Candidate reappears → HELD, no fire.
  - A new key is therefore accepted only after a full release.
- **Fire.**
  - The matching direction output pulses for exactly one clk.
  - `key_code`/`key_valid` update on the same edge and stay until the FSM returns to IDLE.
  - On return to IDLE, `key_code`=4'hF and `key_valid`=0.
- At most one direction output is high in any cycle.
- `cnt` saturates and never wraps.

## Timing

- **Reset values:** `sel`=0, slot counter=0, `up/down/left/right`=0, `key_code`=4'hF, `key_valid`=0, FSM=IDLE, frame vector=0.
- **Reset mid-operation:** clears everything on the next edge; any pending pulse is dropped.
- **Latency:** pulse is asserted in the cycle after the frame end at which cnt reaches DEBOUNCE.
  - Minimum press-to-pulse time is DEBOUNCE frames, up to 1 frame earlier depending on press phase.
- **Release:** a key is released DEBOUNCE frames after the last closed frame.
- **`sel` timing:** `sel` changes one cycle after slot terminal count. `column` is sampled SCAN_DIV-1 cycles after the `sel` change, so the keypad has settling time.

## Configuration

- **`KEYPAD_REPEAT_EN` defined:**
  - While in HELD, a frame counter counts frames.
  - Every REPEAT_FRAMES frames with the key still held, the direction pulse refires for one clk.
  - The counter resets on entry to HELD.
- **`KEYPAD_REPEAT_EN` undefined:** exactly one pulse per press; the repeat counter and `REPEAT_FRAMES` logic are absent.

## Test plan

Bench uses SCAN_DIV=4, DEBOUNCE=3, REPEAT_FRAMES=2 (frame = 24 cycles).

1. **Reset:** hold `reset`=0 for 5 cycles, column=3'b111 → all outputs at reset values; `sel` increments every 4 cycles after release and wraps 5→0.
2. **Single press:** drive column=3'b101 whenever sel=0 for 5 frames → exactly one `up` pulse, 1 cycle wide, after the 3rd frame end; `key_code`=2 and `key_valid`=1 until 3 clean frames after release.
3. **Bounce:** key 6 closed for frames 1,2, open for frame 3, closed for frames 4,5,6 → exactly one `right` pulse, after frame 6.
4. **Simultaneous keys:** column=3'b010 during sel=1 (keys 4 and 6) for 6 frames → no pulse; `key_valid` stays 0.
5. **Held key, two builds:** key 8 held for 10 frames.
   - Without `KEYPAD_REPEAT_EN`: one `down` pulse.
   - With it: pulses at frames 3, 5, 7, 9.
6. **Reset mid-press:** assert `reset` in HELD with key 4 → `key_valid`=0 and `key_code`=4'hF next cycle. If still held after release of reset, one `left` pulse 3 frames later.
